// File: rtl/bus_rx_fifo.sv
// Receiver for a strobed parallel bus: synchronises the active-low strobe,
// captures the bus on its falling edge and queues bytes in a FWFT FIFO.
module bus_rx_fifo #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           bus_in,
    input  logic                       strobe_n,
    output logic [WIDTH-1:0]           rx_data,
    output logic                       rx_valid,
    input  logic                       rx_ready,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       busy_n,
    output logic                       ovr,
    input  logic                       ovr_clr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   fall;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_next;
    logic             full;
    logic             pop;
    logic             push;
    logic             overrun;

    // Flops reset to 0 so a strobe already low at reset release is not a fall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], strobe_n};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign fall     = hist_q & ~sync_q[SYNC_STAGES-1];
    assign full     = (count_q == FULL_COUNT);
    assign rx_valid = (count_q != '0);
    assign pop      = rx_valid & rx_ready;
    // A pop in the same cycle frees the slot, so a write into a full FIFO is still accepted.
    assign push     = fall & (~full | pop);
    assign overrun  = fall & full & ~pop;

    always_comb begin
        count_next = count_q;
        case ({push, pop})
            2'b10:   count_next = count_q + CW'(1);
            2'b01:   count_next = count_q - CW'(1);
            default: count_next = count_q;
        endcase
    end

    // NOTE: the storage array is reset as well, so rx_data reads 0 after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            busy_n  <= 1'b1;
            ovr     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= bus_in;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count_q <= count_next;
            busy_n  <= (count_next != FULL_COUNT);
            if (overrun) begin
                ovr <= 1'b1;
            end else if (ovr_clr) begin
                ovr <= 1'b0;
            end
        end
    end

    assign rx_data    = mem[rd_ptr];
    assign fifo_count = count_q;

endmodule
